// File: rtl/udp_tx_pkt_gen.sv
// udp_tx_pkt_gen: programmable UDP test-traffic burst engine driving the transmit side of udp.
// Define PKT_GEN_STATS_EN to add saturating stat_pkts / stat_bytes counters.
module udp_tx_pkt_gen #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned GAP_W    = 16,
  parameter logic [31:0] INC_STEP = 32'h11111111,
  parameter int unsigned WDOG_CYC = 65535
) (
  input  logic              gmii_tx_clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic [CNT_W-1:0]  cfg_pkt_cnt,
  input  logic [15:0]       cfg_byte_num,
  input  logic [GAP_W-1:0]  cfg_gap,
  input  logic [1:0]        cfg_mode,
  input  logic [31:0]       cfg_seed,
  input  logic [47:0]       cfg_des_mac,
  input  logic [31:0]       cfg_des_ip,
  output logic              tx_start_en,
  output logic [15:0]       tx_byte_num,
  output logic [DATA_W-1:0] tx_data,
  output logic [47:0]       des_mac,
  output logic [31:0]       des_ip,
  input  logic              tx_req,
  input  logic              tx_done,
  output logic              busy,
  output logic              burst_done,
  output logic              wdog_err
`ifdef PKT_GEN_STATS_EN
  ,
  output logic [31:0]       stat_pkts,
  output logic [47:0]       stat_bytes
`endif
);

  localparam int unsigned WDOG_W = $clog2(WDOG_CYC + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);
  localparam logic [DATA_W-1:0] LFSR_MASK = DATA_W'(32'h00400007);
  localparam logic [DATA_W-1:0] RST_DATA  = DATA_W'(32'h00112233);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StGap} state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  data_q, data_d, next_word, seed_q, seed_fix;
  logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d, pkt_cfg_q;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d, gap_cfg_q;
  logic [WDOG_W-1:0]  wdog_cnt_q, wdog_cnt_d;
  logic [1:0]         mode_q;
  logic [15:0]        byte_num_q;
  logic [47:0]        mac_q;
  logic [31:0]        ip_q;
  logic               stop_q, stop_d;
  logic               wdog_err_q, wdog_err_d;
  logic               burst_done_q, burst_done_d;
  logic               start_accept;

  assign start_accept = (state_q == StIdle) && cfg_start && (cfg_byte_num != 16'd0);
  // An all-zero LFSR state would lock up, so mode 2 substitutes 1 for a zero seed.
  assign seed_fix = ((cfg_mode == 2'd2) && (cfg_seed == 32'd0)) ? DATA_W'(1) : DATA_W'(cfg_seed);

  always_comb begin
    case (mode_q)
      2'd0:    next_word = data_q + DATA_W'(INC_STEP);
      2'd2:    next_word = {data_q[DATA_W-2:0], 1'b0} ^ (data_q[DATA_W-1] ? LFSR_MASK : '0);
      default: next_word = data_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    pkt_cnt_d    = pkt_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    wdog_cnt_d   = wdog_cnt_q;
    stop_d       = stop_q;
    wdog_err_d   = wdog_err_q;
    burst_done_d = 1'b0;
    if ((state_q != StIdle) && cfg_stop) stop_d = 1'b1;
    unique case (state_q)
      StIdle: begin
        stop_d = 1'b0;
        if (start_accept) begin
          state_d    = StStart;
          data_d     = seed_fix;
          pkt_cnt_d  = '0;
          wdog_err_d = 1'b0;
        end
      end
      StStart: begin
        state_d    = StWait;
        wdog_cnt_d = '0;
      end
      StWait: begin
        if (tx_done) begin
          pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
          data_d    = seed_q;
          gap_cnt_d = gap_cfg_q;
          state_d   = StGap;
        end else begin
          if (tx_req) data_d = next_word;
          if (wdog_cnt_q == WDOG_LAST) begin
            state_d    = StIdle;
            wdog_err_d = 1'b1;
            stop_d     = 1'b0;
          end else begin
            wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
          end
        end
      end
      StGap: begin
        // A zero count here is the end-condition evaluation cycle.
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end else if (stop_q || cfg_stop || ((pkt_cfg_q != '0) && (pkt_cnt_q == pkt_cfg_q))) begin
          state_d      = StIdle;
          burst_done_d = 1'b1;
          stop_d       = 1'b0;
        end else begin
          state_d = StStart;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      data_q       <= RST_DATA;
      pkt_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      wdog_cnt_q   <= '0;
      stop_q       <= 1'b0;
      wdog_err_q   <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      pkt_cnt_q    <= pkt_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      wdog_cnt_q   <= wdog_cnt_d;
      stop_q       <= stop_d;
      wdog_err_q   <= wdog_err_d;
      burst_done_q <= burst_done_d;
    end
  end

  // Burst configuration is frozen at launch.
  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_q     <= '0;
      mode_q     <= 2'd0;
      pkt_cfg_q  <= '0;
      gap_cfg_q  <= '0;
      byte_num_q <= 16'd0;
      mac_q      <= 48'd0;
      ip_q       <= 32'd0;
    end else if (start_accept) begin
      seed_q     <= seed_fix;
      mode_q     <= cfg_mode;
      pkt_cfg_q  <= cfg_pkt_cnt;
      gap_cfg_q  <= cfg_gap;
      byte_num_q <= cfg_byte_num;
      mac_q      <= cfg_des_mac;
      ip_q       <= cfg_des_ip;
    end
  end

  assign tx_start_en = (state_q == StStart);
  assign busy        = (state_q != StIdle);
  assign burst_done  = burst_done_q;
  assign wdog_err    = wdog_err_q;
  assign tx_data     = data_q;
  assign tx_byte_num = byte_num_q;
  assign des_mac     = mac_q;
  assign des_ip      = ip_q;

`ifdef PKT_GEN_STATS_EN
  logic [31:0] stat_pkts_q;
  logic [47:0] stat_bytes_q;
  logic [48:0] bytes_sum;

  assign bytes_sum = {1'b0, stat_bytes_q} + 49'(byte_num_q);

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pkts_q  <= '0;
      stat_bytes_q <= '0;
    end else if (start_accept) begin
      stat_pkts_q  <= '0;
      stat_bytes_q <= '0;
    end else if ((state_q == StWait) && tx_done) begin
      if (stat_pkts_q != '1) stat_pkts_q <= stat_pkts_q + 32'd1;
      stat_bytes_q <= bytes_sum[48] ? '1 : bytes_sum[47:0];
    end
  end

  assign stat_pkts  = stat_pkts_q;
  assign stat_bytes = stat_bytes_q;
`endif

endmodule
